// File: rtl/slave_readback_pkg.sv
// -----------------------------------------------------------------------------
// slave_readback_pkg
// Shared types and helpers for the slave-memory readback block.
//   state_t      : readback FSM states (IDLE, ISSUE, WAIT, PUSH, FIN)
//   DEF_*        : default configuration constants (element bytes, index width)
//   idx_width()  : element-index width for a given element count (never 0)
//   elem_addr()  : byte address of an element, full 32-bit result
// -----------------------------------------------------------------------------
package slave_readback_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        PUSH  = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam int unsigned DEF_ELEM_BITS  = 32;
    localparam int unsigned DEF_ELEM_BYTES = DEF_ELEM_BITS / 8;
    localparam int unsigned DEF_NWORDS     = 100;
    localparam int unsigned DEF_IDX_W      = $clog2(DEF_NWORDS);

    // A single-element run still needs a 1-bit index port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Caller truncates to the slave address width.
    function automatic logic [31:0] elem_addr(input logic [31:0] base,
                                              input logic [31:0] index,
                                              input logic [31:0] elem_bytes);
        return base + index * elem_bytes;
    endfunction

endpackage

// File: rtl/readback_timeout_ctr.sv
// -----------------------------------------------------------------------------
// readback_timeout_ctr
// Loadable up-counter with terminal-count flag, used to bound the wait for
// read data.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   load  : clear the count to 0 (has priority over en)
//   en    : count up by one; holds once the terminal value is reached
//   tc    : high while the count equals TERMINAL
// -----------------------------------------------------------------------------
module readback_timeout_ctr #(
    parameter int unsigned TERMINAL = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = (TERMINAL > 0) ? $clog2(TERMINAL + 1) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc = (count_q == CNT_W'(TERMINAL));

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (en && !tc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/slave_mem_readback.sv
// -----------------------------------------------------------------------------
// slave_mem_readback
// Reads NWORDS elements out of the HLS core's memory over its slave RAM port,
// one read per element, and streams them on a valid/ready output.
//   clock, reset           : clock and asynchronous active-low reset
//   start                  : one-cycle run request, taken only in IDLE
//   S_oe_ram / S_we_ram    : slave read enable (1-cycle pulse) / write enable (0)
//   S_addr_ram             : byte address BASE_ADDR + index*ELEM_BYTES
//   S_Wdata_ram            : constant 0, the core memory is never written
//   S_data_ram_size        : access size in bits (ELEM_BITS)
//   Sout_Rdata_ram         : read data, low ELEM_BITS are kept
//   Sout_DataRdy           : read data valid, only looked at in WAIT
//   out_valid/out_ready    : element stream handshake
//   out_data / out_index   : element value and its index
//   busy / done            : run in progress / one-cycle end-of-run pulse
//   err_timeout            : sticky, set when DataRdy does not arrive in time
//   dbg_state              : current FSM state
// Optional (macro READBACK_ORDER_CHECK_EN): order_err, order_err_index flag the
// first element that is smaller (signed) than its predecessor.
//
// Output stream handshake: out_valid rises with out_data/out_index and all
// three stay stable until a cycle with out_valid && out_ready; that cycle
// transfers the element and out_valid drops on the next edge. out_ready is
// ignored while out_valid is low.
// -----------------------------------------------------------------------------
module slave_mem_readback
    import slave_readback_pkg::*;
#(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned SIZE_W    = 7,
    parameter int unsigned ELEM_BITS = 32,
    parameter int unsigned NWORDS    = 100,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned TIMEOUT   = 255,
    localparam int unsigned IDX_W    = idx_width(NWORDS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic                 S_oe_ram,
    output logic                 S_we_ram,
    output logic [ADDR_W-1:0]    S_addr_ram,
    output logic [DATA_W-1:0]    S_Wdata_ram,
    output logic [SIZE_W-1:0]    S_data_ram_size,
    input  logic [DATA_W-1:0]    Sout_Rdata_ram,
    input  logic                 Sout_DataRdy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ELEM_BITS-1:0] out_data,
    output logic [IDX_W-1:0]     out_index,
    output logic                 busy,
    output logic                 done,
    output state_t               dbg_state,
    output logic                 err_timeout
`ifdef READBACK_ORDER_CHECK_EN
    ,
    output logic                 order_err,
    output logic [IDX_W-1:0]     order_err_index
`endif
);

    localparam int unsigned ELEM_BYTES = ELEM_BITS / 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    state_t                 state_q,    state_d;
    logic [IDX_W-1:0]       idx_q,      idx_d;
    logic                   oe_q,       oe_d;
    logic [ADDR_W-1:0]      addr_q,     addr_d;
    logic [SIZE_W-1:0]      size_q,     size_d;
    logic                   valid_q,    valid_d;
    logic [ELEM_BITS-1:0]   data_q,     data_d;
    logic [IDX_W-1:0]       oidx_q,     oidx_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;
    logic                   tmo_q,      tmo_d;
`ifdef READBACK_ORDER_CHECK_EN
    logic [ELEM_BITS-1:0]   prev_q,     prev_d;
    logic                   oerr_q,     oerr_d;
    logic [IDX_W-1:0]       oerr_idx_q, oerr_idx_d;
`endif

    logic ctr_load;
    logic ctr_en;
    logic ctr_tc;

    // Only the low ELEM_BITS of the read bus carry the element.
    logic unused_rdata;
    assign unused_rdata = ^Sout_Rdata_ram;

    readback_timeout_ctr #(
        .TERMINAL (TIMEOUT)
    ) u_wait_ctr (
        .clock (clock),
        .reset (reset),
        .load  (ctr_load),
        .en    (ctr_en),
        .tc    (ctr_tc)
    );

    function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] i);
        return ADDR_W'(elem_addr(32'(BASE_ADDR), 32'(i), 32'(ELEM_BYTES)));
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        oe_d     = 1'b0;
        addr_d   = addr_q;
        size_d   = size_q;
        valid_d  = valid_q;
        data_d   = data_q;
        oidx_d   = oidx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tmo_d    = tmo_q;
        ctr_load = 1'b0;
        ctr_en   = 1'b0;
`ifdef READBACK_ORDER_CHECK_EN
        prev_d     = prev_q;
        oerr_d     = oerr_q;
        oerr_idx_d = oerr_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    tmo_d   = 1'b0;
                    oe_d    = 1'b1;
                    addr_d  = addr_of('0);
                    size_d  = SIZE_W'(ELEM_BITS);
`ifdef READBACK_ORDER_CHECK_EN
                    oerr_d     = 1'b0;
                    oerr_idx_d = '0;
`endif
                end
            end
            ISSUE: begin
                state_d  = WAIT;
                ctr_load = 1'b1;
            end
            WAIT: begin
                ctr_en = 1'b1;
                // Data wins over a timeout arriving in the same cycle.
                if (Sout_DataRdy) begin
                    data_d  = Sout_Rdata_ram[ELEM_BITS-1:0];
                    oidx_d  = idx_q;
                    valid_d = 1'b1;
                    state_d = PUSH;
                end else if (ctr_tc) begin
                    tmo_d   = 1'b1;
                    state_d = FIN;
                end
            end
            PUSH: begin
                if (out_ready) begin
                    valid_d = 1'b0;
`ifdef READBACK_ORDER_CHECK_EN
                    if ((idx_q != '0) && !oerr_q &&
                        ($signed(data_q) < $signed(prev_q))) begin
                        oerr_d     = 1'b1;
                        oerr_idx_d = idx_q;
                    end
                    prev_d = data_q;
`endif
                    if (idx_q == LAST_IDX) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        oe_d    = 1'b1;
                        addr_d  = addr_of(idx_q + 1'b1);
                        size_d  = SIZE_W'(ELEM_BITS);
                        state_d = ISSUE;
                    end
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            oe_q       <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            oidx_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
`ifdef READBACK_ORDER_CHECK_EN
            prev_q     <= '0;
            oerr_q     <= 1'b0;
            oerr_idx_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            oe_q       <= oe_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            oidx_q     <= oidx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
`ifdef READBACK_ORDER_CHECK_EN
            prev_q     <= prev_d;
            oerr_q     <= oerr_d;
            oerr_idx_q <= oerr_idx_d;
`endif
        end
    end

    assign S_oe_ram        = oe_q;
    assign S_we_ram        = 1'b0;
    assign S_addr_ram      = addr_q;
    assign S_Wdata_ram     = '0;
    assign S_data_ram_size = size_q;
    assign out_valid       = valid_q;
    assign out_data        = data_q;
    assign out_index       = oidx_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err_timeout     = tmo_q;
    assign dbg_state       = state_q;
`ifdef READBACK_ORDER_CHECK_EN
    assign order_err       = oerr_q;
    assign order_err_index = oerr_idx_q;
`endif

endmodule

// File: tb/tb_slave_mem_readback.sv
// -----------------------------------------------------------------------------
// tb_slave_mem_readback
// Directed bench for slave_mem_readback: memory model with a 2-cycle read
// delay, a consumer with programmable back-pressure, and a scoreboard holding
// the expected element stream.
// -----------------------------------------------------------------------------
module tb_slave_mem_readback;
    import slave_readback_pkg::*;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 64;
    localparam int SIZE_W = 7;
    localparam int EB     = 32;
    localparam int NW     = 100;
    localparam int IW     = 7;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic              start = 1'b0;
    logic              S_oe_ram, S_we_ram;
    logic [ADDR_W-1:0] S_addr_ram;
    logic [DATA_W-1:0] S_Wdata_ram;
    logic [SIZE_W-1:0] S_data_ram_size;
    logic [DATA_W-1:0] Sout_Rdata_ram;
    logic              Sout_DataRdy;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [EB-1:0]     out_data;
    logic [IW-1:0]     out_index;
    logic              busy, done, err_timeout;
    state_t            dbg_state;
`ifdef READBACK_ORDER_CHECK_EN
    logic              order_err;
    logic [IW-1:0]     order_err_index;
`endif

    slave_mem_readback dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .S_oe_ram        (S_oe_ram),
        .S_we_ram        (S_we_ram),
        .S_addr_ram      (S_addr_ram),
        .S_Wdata_ram     (S_Wdata_ram),
        .S_data_ram_size (S_data_ram_size),
        .Sout_Rdata_ram  (Sout_Rdata_ram),
        .Sout_DataRdy    (Sout_DataRdy),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_index       (out_index),
        .busy            (busy),
        .done            (done),
        .dbg_state       (dbg_state),
        .err_timeout     (err_timeout)
`ifdef READBACK_ORDER_CHECK_EN
        ,
        .order_err       (order_err),
        .order_err_index (order_err_index)
`endif
    );

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory model: 2-cycle read delay ----------------
    logic [31:0]       mem [0:127];
    int                drop_idx  = -1;
    logic              stray_rdy = 1'b0;
    logic              p0 = 1'b0, p1 = 1'b0;
    logic [ADDR_W-1:0] a0 = '0, a1 = '0;

    always @(posedge clock) begin
        p0 <= S_oe_ram;
        a0 <= S_addr_ram;
        p1 <= p0 && ((int'(a0) >> 2) != drop_idx);
        a1 <= a0;
    end

    assign Sout_DataRdy   = p1 | stray_rdy;
    assign Sout_Rdata_ram = p1 ? {32'hDEAD_BEEF, mem[a1[8:2]]} : 64'h0;

    // ---------------- consumer driver ----------------
    int hold_idx = -1;
    int hold_len = 0;
    int hold_cnt = 0;

    always @(posedge clock) begin
        #1;
        if (out_valid && (int'(out_index) == hold_idx) && (hold_cnt < hold_len)) begin
            out_ready = 1'b0;
            hold_cnt++;
        end else begin
            out_ready = 1'b1;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [31:0] exp_q[$];
    int acc_cnt   = 0;
    int done_cnt  = 0;
    int stall_cnt = 0;

    always @(negedge clock) begin
        if (reset) begin
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                check("elem_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("elem_data", out_data, exp_q.pop_front());
                check("elem_index", out_index, acc_cnt);
                acc_cnt++;
            end
            if (out_valid && !out_ready) begin
                stall_cnt++;
                check("stall_data", out_data, hold_idx);
                check("stall_no_oe", S_oe_ram, 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_mem(input bit swap);
        for (int i = 0; i < 128; i++) mem[i] = i;
        if (swap) begin
            mem[9]  = 10;
            mem[10] = 9;
        end
    endtask

    task automatic run(input int n_exp, input int restart_at, output int cyc);
        acc_cnt  = 0;
        done_cnt = 0;
        exp_q.delete();
        for (int i = 0; i < n_exp; i++) exp_q.push_back(mem[i]);
        @(posedge clock); #1;
        start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clock); #1;
            cyc++;
            start = (cyc == restart_at);
            if (cyc == 1) begin
                check("busy_after_start", busy, 1);
                check("tmo_cleared", err_timeout, 0);
                check("issue_oe", S_oe_ram, 1);
                check("issue_addr", S_addr_ram, 0);
                check("issue_size", S_data_ram_size, 32);
            end
        end while (!done && cyc < 3000);
        check("done_seen", done, 1);
        repeat (3) @(posedge clock);
        #1;
        check("done_pulses", done_cnt, 1);
        check("elem_count", acc_cnt, n_exp);
        check("busy_end", busy, 0);
        check("done_dropped", done, 0);
        check("state_idle", dbg_state, IDLE);
    endtask

    // ---------------- directed sequence ----------------
    int cyc;

    initial begin
        load_mem(0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_oe", S_oe_ram, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", S_addr_ram, 0);
        check("rst_state", dbg_state, IDLE);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        // 1: full run, ready always high; 4 cycles/element + FIN + done register
        run(NW, 0, cyc);
        check("run_cycles", cyc, 402);
        check("t1_tmo", err_timeout, 0);
        check("t1_we", S_we_ram, 0);
        check("t1_wdata", S_Wdata_ram, 0);

        // 2: back-pressure on element 7 for 5 cycles
        hold_idx = 7; hold_len = 5; hold_cnt = 0; stall_cnt = 0;
        run(NW, 0, cyc);
        check("t2_stall_cycles", stall_cnt, 5);
        check("t2_run_cycles", cyc, 407);
        hold_idx = -1;

        // 3: memory never answers element 3 -> timeout after elements 0..2
        drop_idx = 3;
        run(3, 0, cyc);
        check("t3_tmo", err_timeout, 1);
        check("t3_cycles_lo", 64'(cyc >= 270), 1);
        check("t3_cycles_hi", 64'(cyc <= 272), 1);
        drop_idx = -1;

        // 4: reset while element 50 sits in PUSH
        hold_idx = 50; hold_len = 100000; hold_cnt = 0;
        acc_cnt = 0; done_cnt = 0; exp_q.delete();
        for (int i = 0; i < NW; i++) exp_q.push_back(mem[i]);
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 0;
        while (!(out_valid && int'(out_index) == 50) && cyc < 1000) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("t4_reached_50", out_index, 50);
        check("t4_tmo_cleared", err_timeout, 0);
        reset = 1'b0;
        #1;
        check("t4_rst_valid", out_valid, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_data", out_data, 0);
        check("t4_rst_index", out_index, 0);
        check("t4_rst_state", dbg_state, IDLE);
        hold_idx = -1;
        repeat (3) @(posedge clock);
        #1;
        check("t4_no_done", done_cnt, 0);
        reset = 1'b1;
        run(NW, 0, cyc);
        check("t4_rerun_cycles", cyc, 402);

        // 5: stray DataRdy in IDLE, then a second start mid-run
        @(posedge clock); #1;
        stray_rdy = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        stray_rdy = 1'b0;
        check("t5_stray_valid", out_valid, 0);
        check("t5_stray_busy", busy, 0);
        run(NW, 50, cyc);
        check("t5_run_cycles", cyc, 402);

`ifdef READBACK_ORDER_CHECK_EN
        // 6: elements 9 and 10 swapped -> first decrease at index 10
        load_mem(1);
        run(NW, 0, cyc);
        check("t6_order_err", order_err, 1);
        check("t6_order_idx", order_err_index, 10);
        load_mem(0);
        run(NW, 0, cyc);
        check("t6_sorted_err", order_err, 0);
        check("t6_sorted_idx", order_err_index, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
